// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e    : FSM state encoding
//   NOP_INSTR        : bubble written into IF/ID on a flush
//   RESET_PC_DEFAULT : default PC after reset
//   PC_INC_DEFAULT   : default sequential increment in bytes
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
//   req   : fetch request (master -> slave)
//   addr  : fetch address, stable while req=1 and ready=0
//   ready : rdata valid, completes the outstanding request
//   rdata : fetched instruction word
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory and feeds the IF/ID register with either a real
// instruction (ifid_write_o) or a NOP bubble (if_flush_o).
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall_i         : hazard stall, holds PC and IF/ID
//   redirect_i      : taken branch/jump from ID, overrides stall
//   redirect_pc_i   : redirect target
//   imem            : instruction-memory bus (master side)
//   instr_o, pc_o   : IF/ID INSTRin and PCin (PC+4)
//   ifid_write_o    : IF/ID write enable
//   if_flush_o      : IF/ID flush (load NOP)
//
// state   | meaning
// FETCH   | request to pc outstanding; response consumed, parked or dropped
// HOLD    | response parked in buf_q while stalled; no request outstanding
// DISCARD | request to req_addr_q outstanding but stale after a redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr_o,
  output logic [31:0]         pc_o,
  output logic                ifid_write_o,
  output logic                if_flush_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  req_addr_q, req_addr_d;

  logic         req_c, wr_c, fl_c;
  logic [31:0]  addr_c, instr_c, pc_out_c;
  logic [31:0]  pc_inc;

  assign pc_inc = pc_q + PC_INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      buf_q      <= NOP_INSTR;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    req_addr_d = req_addr_q;
    req_c      = 1'b0;
    addr_c     = pc_q;
    wr_c       = 1'b0;
    fl_c       = 1'b0;
    instr_c    = NOP_INSTR;
    pc_out_c   = pc_inc;

    unique case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (redirect_i) begin
          fl_c     = 1'b1;
          pc_out_c = redirect_pc_i;
          pc_d     = redirect_pc_i;
          buf_d    = NOP_INSTR;
          // The in-flight request can't be cancelled; remember its address
          // so it stays on the bus until the memory completes it.
          if (!imem.ready) begin
            req_addr_d = pc_q;
            state_d    = DISCARD;
          end
        end else if (imem.ready) begin
          if (!stall_i) begin
            wr_c    = 1'b1;
            instr_c = imem.rdata;
            pc_d    = pc_inc;
          end else begin
            buf_d   = imem.rdata;
            state_d = HOLD;
          end
        end else if (!stall_i) begin
          fl_c = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          fl_c     = 1'b1;
          pc_out_c = redirect_pc_i;
          pc_d     = redirect_pc_i;
          buf_d    = NOP_INSTR;
          state_d  = FETCH;
        end else if (!stall_i) begin
          wr_c    = 1'b1;
          instr_c = buf_q;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end

      DISCARD: begin
        req_c  = 1'b1;
        addr_c = req_addr_q;
        if (redirect_i) begin
          fl_c     = 1'b1;
          pc_out_c = redirect_pc_i;
          pc_d     = redirect_pc_i;
        end else begin
          fl_c = !stall_i;
        end
        if (imem.ready) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Outputs are gated by rst_n so they drop to zero the moment reset asserts,
  // not at the next edge.
  assign imem.req     = rst_n & req_c;
  assign imem.addr    = addr_c;
  assign ifid_write_o = rst_n & wr_c;
  assign if_flush_o   = rst_n & fl_c;
  assign instr_o      = rst_n ? instr_c  : '0;
  assign pc_o         = rst_n ? pc_out_c : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        ifid_write;
  logic        if_flush;

  int errors = 0;
  int checks = 0;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem         (imem_bus),
    .instr_o      (instr_out),
    .pc_o         (pc_out),
    .ifid_write_o (ifid_write),
    .if_flush_o   (if_flush)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic rdy, input logic [31:0] data);
    stall            = st;
    redirect         = rd;
    redirect_pc      = rpc;
    imem_bus.ready   = rdy;
    imem_bus.rdata   = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000", {imem_bus.req, ifid_write, if_flush});
    end
    checks++;
    if ({instr_out, pc_out} !== 64'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {instr_out, pc_out});
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_0005);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b110 || imem_bus.addr !== 32'h0) begin
      errors++; $display("FAIL zw_first ctrl=%b addr=%h exp 110/0", {imem_bus.req, ifid_write, if_flush}, imem_bus.addr);
    end
    checks++;
    if (instr_out !== 32'h2008_0005 || pc_out !== 32'h4) begin
      errors++; $display("FAIL zw_data instr=%h pc=%h exp 20080005/4", instr_out, pc_out);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_1111);
    checks++;
    if (imem_bus.addr !== 32'h4 || ifid_write !== 1'b1 || pc_out !== 32'h8) begin
      errors++; $display("FAIL zw_second addr=%h wr=%b pc=%h exp 4/1/8", imem_bus.addr, ifid_write, pc_out);
    end
    tick();
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if ({imem_bus.req, ifid_write, if_flush} !== 3'b101 || imem_bus.addr !== 32'h8) begin
        errors++; $display("FAIL ws_wait%0d ctrl=%b addr=%h exp 101/8", i, {imem_bus.req, ifid_write, if_flush}, imem_bus.addr);
      end
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2222);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b110 || pc_out !== 32'hC || instr_out !== 32'h0000_2222) begin
      errors++; $display("FAIL ws_done ctrl=%b pc=%h instr=%h exp 110/c/2222", {imem_bus.req, ifid_write, if_flush}, pc_out, instr_out);
    end
    tick();
  endtask

  task automatic test_stall_hold();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3333);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h8C09_0000);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b100 || imem_bus.addr !== 32'h10) begin
      errors++; $display("FAIL sh_capture ctrl=%b addr=%h exp 100/10", {imem_bus.req, ifid_write, if_flush}, imem_bus.addr);
    end
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b000) begin
      errors++; $display("FAIL sh_hold ctrl=%b exp 000", {imem_bus.req, ifid_write, if_flush});
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b010 || instr_out !== 32'h8C09_0000 || pc_out !== 32'h14) begin
      errors++; $display("FAIL sh_release ctrl=%b instr=%h pc=%h exp 010/8c090000/14", {imem_bus.req, ifid_write, if_flush}, instr_out, pc_out);
    end
    tick();
  endtask

  task automatic test_redirect_discard();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
      tick();
    end
    set_in(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b101 || imem_bus.addr !== 32'h20 || pc_out !== 32'h40) begin
      errors++; $display("FAIL rd_assert ctrl=%b addr=%h pc=%h exp 101/20/40", {imem_bus.req, ifid_write, if_flush}, imem_bus.addr, pc_out);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b101 || imem_bus.addr !== 32'h20) begin
      errors++; $display("FAIL rd_wait ctrl=%b addr=%h exp 101/20", {imem_bus.req, ifid_write, if_flush}, imem_bus.addr);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (ifid_write !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h20) begin
      errors++; $display("FAIL rd_drop wr=%b req=%b addr=%h exp 0/1/20", ifid_write, imem_bus.req, imem_bus.addr);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_4444);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b110 || imem_bus.addr !== 32'h40 ||
        pc_out !== 32'h44 || instr_out !== 32'h0000_4444) begin
      errors++; $display("FAIL rd_target ctrl=%b addr=%h pc=%h instr=%h exp 110/40/44/4444",
                         {imem_bus.req, ifid_write, if_flush}, imem_bus.addr, pc_out, instr_out);
    end
    tick();
  endtask

  task automatic test_redirect_in_hold();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_5555);
    tick();
    set_in(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b001 || pc_out !== 32'h80) begin
      errors++; $display("FAIL rh_redirect ctrl=%b pc=%h exp 001/80", {imem_bus.req, ifid_write, if_flush}, pc_out);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b101 || imem_bus.addr !== 32'h80) begin
      errors++; $display("FAIL rh_next ctrl=%b addr=%h exp 101/80", {imem_bus.req, ifid_write, if_flush}, imem_bus.addr);
    end
    tick();
  endtask

  task automatic test_reset_mid_discard();
    set_in(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (imem_bus.addr !== 32'h80 || if_flush !== 1'b1) begin
      errors++; $display("FAIL rm_discard addr=%h fl=%b exp 80/1", imem_bus.addr, if_flush);
    end
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_7777);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b000 || instr_out !== 32'h0 || pc_out !== 32'h0) begin
      errors++; $display("FAIL rm_async ctrl=%b instr=%h pc=%h exp 000/0/0", {imem_bus.req, ifid_write, if_flush}, instr_out, pc_out);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b101 || imem_bus.addr !== 32'h0) begin
      errors++; $display("FAIL rm_release ctrl=%b addr=%h exp 101/0", {imem_bus.req, ifid_write, if_flush}, imem_bus.addr);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_9999);
    checks++;
    if (ifid_write !== 1'b1 || pc_out !== 32'h4 || instr_out !== 32'h0000_9999) begin
      errors++; $display("FAIL rm_fetch wr=%b pc=%h instr=%h exp 1/4/9999", ifid_write, pc_out, instr_out);
    end
    tick();
  endtask

  task automatic test_wrap();
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_1234);
    checks++;
    if ({imem_bus.req, ifid_write, if_flush} !== 3'b101 || pc_out !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wr_redirect ctrl=%b pc=%h exp 101/fffffffc", {imem_bus.req, ifid_write, if_flush}, pc_out);
    end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_ABCD);
    checks++;
    if (imem_bus.addr !== 32'hFFFF_FFFC || ifid_write !== 1'b1 || pc_out !== 32'h0) begin
      errors++; $display("FAIL wr_wrap addr=%h wr=%b pc=%h exp fffffffc/1/0", imem_bus.addr, ifid_write, pc_out);
    end
    tick();
  endtask

  // Reference model: PC, an optional parked instruction and an optional stale
  // outstanding request. Starts from PC=0 with nothing parked or stale.
  task automatic test_random();
    logic [31:0] m_pc = 32'h0;
    logic        m_held = 1'b0;
    logic [31:0] m_held_data = 32'h0;
    logic        m_stale = 1'b0;
    logic [31:0] m_stale_addr = 32'h0;
    logic        st, rd, rdy, e_req, e_wr, e_fl;
    logic [31:0] rpc, data, e_addr, e_instr, e_pcout;
    for (int n = 0; n < 3000; n++) begin
      st     = ($urandom % 4) == 0;
      rd     = ($urandom % 8) == 0;
      rpc    = $urandom & 32'hFFFF_FFFC;
      e_req  = !m_held;
      e_addr = m_stale ? m_stale_addr : m_pc;
      rdy    = e_req ? (($urandom % 2) == 1) : 1'b0;
      data   = mem_word(e_addr);
      set_in(st, rd, rpc, rdy, data);

      e_wr = 1'b0; e_fl = 1'b0; e_instr = 32'h0; e_pcout = m_pc + 32'd4;
      if (rd) begin
        e_fl = 1'b1; e_pcout = rpc;
        if (m_stale) begin
          if (rdy) m_stale = 1'b0;
        end else if (!m_held && !rdy) begin
          m_stale = 1'b1; m_stale_addr = m_pc;
        end
        m_held = 1'b0; m_pc = rpc;
      end else if (m_held) begin
        if (!st) begin
          e_wr = 1'b1; e_instr = m_held_data; m_pc = m_pc + 32'd4; m_held = 1'b0;
        end
      end else if (m_stale) begin
        e_fl = !st;
        if (rdy) m_stale = 1'b0;
      end else if (rdy) begin
        if (!st) begin
          e_wr = 1'b1; e_instr = data; m_pc = m_pc + 32'd4;
        end else begin
          m_held = 1'b1; m_held_data = data;
        end
      end else begin
        e_fl = !st;
      end

      checks++;
      if ({imem_bus.req, ifid_write, if_flush} !== {e_req, e_wr, e_fl}) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", n, {imem_bus.req, ifid_write, if_flush}, {e_req, e_wr, e_fl});
      end
      if (e_req) begin
        checks++;
        if (imem_bus.addr !== e_addr) begin
          errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, imem_bus.addr, e_addr);
        end
      end
      if (e_wr || rd) begin
        checks++;
        if (pc_out !== e_pcout || (e_wr && instr_out !== e_instr)) begin
          errors++; $display("FAIL rnd_data cyc=%0d pc=%h exp=%h instr=%h exp=%h", n, pc_out, e_pcout, instr_out, e_instr);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect_discard();
    test_redirect_in_hold();
    test_reset_mid_discard();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
